// File: rtl/spi_ram_arbiter_pkg.sv
// Shared constants for the SPI RAM arbiter: RAM command codes, FSM state encoding
// and the default parameter values.
package spi_ram_arb_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 8;
  localparam int TX_TIMEOUT_DEF = 15;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_ADDR    = 3'd1,
    ARB_DATA    = 3'd2,
    ARB_WAIT_TX = 3'd3,
    ARB_RESP    = 3'd4
  } arb_state_e;

endpackage

// File: rtl/spi_ram_arbiter_if.sv
// Requester and RAM-side signal bundle for spi_ram_arbiter; the arbiter sits on the
// slave modport, requesters plus the RAM (or a bench) drive the master modport.
interface spi_ram_arbiter_if
  import spi_ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [1:0]          req;
  logic [1:0]          req_we;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          gnt;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;
  logic [ADDR_W+1:0]   ram_din;
  logic                ram_rx_valid;
  logic [DATA_W-1:0]   ram_dout;
  logic                ram_tx_valid;
  logic                busy;

  modport slave (
    input  req, req_we, req_addr, req_wdata, ram_dout, ram_tx_valid,
    output gnt, rsp_valid, rsp_rdata, rsp_err, ram_din, ram_rx_valid, busy
  );

  modport master (
    output req, req_we, req_addr, req_wdata, ram_dout, ram_tx_valid,
    input  gnt, rsp_valid, rsp_rdata, rsp_err, ram_din, ram_rx_valid, busy
  );

endinterface

// File: rtl/spi_ram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; the requester that did not win last time
// wins a tie, and the history only advances when the pick is actually taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       valid_o,
  output logic       id_o
);

  logic last_q;

  always_comb begin
    valid_o = |req_i;
    case (req_i)
      2'b01:   id_o = 1'b0;
      2'b10:   id_o = 1'b1;
      2'b11:   id_o = ~last_q;
      default: id_o = 1'b0;
    endcase
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (take_i && valid_o) begin
      last_q <= id_o;
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: shares the SPI-slave RAM between two requesters, one transaction at a time.
// Optional macro SPI_RAM_ARB_TIMEOUT_EN bounds WAIT_TX and completes stalled reads with rsp_err.
module spi_ram_arbiter
  import spi_ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef SPI_RAM_ARB_TIMEOUT_EN
  ,
  parameter int TX_TIMEOUT = TX_TIMEOUT_DEF
`endif
) (
  input logic              clk,
  input logic              rst,
  spi_ram_arbiter_if.slave bus
);

  localparam logic [2:0] ST_IDLE    = ARB_IDLE;
  localparam logic [2:0] ST_ADDR    = ARB_ADDR;
  localparam logic [2:0] ST_DATA    = ARB_DATA;
  localparam logic [2:0] ST_WAIT_TX = ARB_WAIT_TX;
  localparam logic [2:0] ST_RESP    = ARB_RESP;

  logic [2:0]        state_q, state_d;
  logic              id_q, id_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W+1:0] din_q, din_d;
  logic              rx_valid_q, rx_valid_d;
  logic              arb_valid;
  logic              arb_id;
`ifdef SPI_RAM_ARB_TIMEOUT_EN
  logic [3:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              rsp_err_q, rsp_err_d;
`endif

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .req_i   (bus.req),
    .take_i  (state_q == ST_IDLE),
    .valid_o (arb_valid),
    .id_o    (arb_id)
  );

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    din_d       = din_q;
    rx_valid_d  = 1'b0;
`ifdef SPI_RAM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
    rsp_err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          id_d    = arb_id;
          we_d    = bus.req_we[arb_id];
          addr_d  = bus.req_addr[int'(arb_id)*ADDR_W +: ADDR_W];
          wdata_d = bus.req_wdata[int'(arb_id)*DATA_W +: DATA_W];
          gnt_d   = 2'b01 << arb_id;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        din_d      = {(we_q ? CMD_WR_ADDR : CMD_RD_ADDR), addr_q};
        rx_valid_d = 1'b1;
        state_d    = ST_DATA;
      end
      ST_DATA: begin
        rx_valid_d = 1'b1;
        if (we_q) begin
          din_d   = {CMD_WR_DATA, ADDR_W'(wdata_q)};
          state_d = ST_RESP;
        end else begin
          din_d   = {CMD_RD_DATA, {ADDR_W{1'b0}}};
          state_d = ST_WAIT_TX;
        end
`ifdef SPI_RAM_ARB_TIMEOUT_EN
        cnt_d = '0;
        err_d = 1'b0;
`endif
      end
      // A tx_valid arriving on the timeout cycle still completes the read normally.
      ST_WAIT_TX: begin
        if (bus.ram_tx_valid) begin
          rdata_d = bus.ram_dout;
          state_d = ST_RESP;
        end
`ifdef SPI_RAM_ARB_TIMEOUT_EN
        else if (cnt_q == 4'(TX_TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
`endif
      end
      ST_RESP: begin
        rsp_valid_d = 2'b01 << id_q;
        rsp_rdata_d = we_q ? '0 : rdata_q;
`ifdef SPI_RAM_ARB_TIMEOUT_EN
        rsp_err_d = err_q;
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      id_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      din_q       <= '0;
      rx_valid_q  <= 1'b0;
`ifdef SPI_RAM_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      din_q       <= din_d;
      rx_valid_q  <= rx_valid_d;
`ifdef SPI_RAM_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.ram_din      = din_q;
  assign bus.ram_rx_valid = rx_valid_q;
  assign bus.busy         = (state_q != ST_IDLE);
`ifdef SPI_RAM_ARB_TIMEOUT_EN
  assign bus.rsp_err      = rsp_err_q;
`else
  assign bus.rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Self-checking bench for spi_ram_arbiter: directed cases plus randomized transactions
// checked against a transaction-level model of arbitration, commands and responses.
module tb_spi_ram_arbiter;

  localparam int TxTimeout = 15;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic rrLast;

  spi_ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  spi_ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] we, input logic [15:0] addr, input logic [15:0] wdata);
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  task automatic doReset(input int n);
    rst = 1'b1;
    bus.req = 2'b00;
    bus.ram_tx_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
    rst = 1'b0;
    rrLast = 1'b1;
  endtask

  // One full transaction: the model picks the winner, predicts both RAM commands and the response.
  // txDelay < 0 means the RAM never answers a read.
  task automatic doTxn(input logic [1:0] mask, input bit holdReq, input int txDelay, input logic [7:0] ramData);
    logic       expId;
    logic       expWe;
    logic [7:0] expAddr;
    logic [7:0] expWdata;
    logic [1:0] oneHot;
    expId    = (mask == 2'b11) ? ~rrLast : mask[1];
    expWe    = bus.req_we[expId];
    expAddr  = bus.req_addr[int'(expId)*8 +: 8];
    expWdata = bus.req_wdata[int'(expId)*8 +: 8];
    oneHot   = expId ? 2'b10 : 2'b01;
    rrLast   = expId;
    bus.req  = mask;
    tick();
    checkOutput("gnt", {14'd0, bus.gnt}, {14'd0, oneHot});
    checkOutput("busy_after_gnt", {15'd0, bus.busy}, 16'd1);
    checkOutput("rx_during_gnt", {15'd0, bus.ram_rx_valid}, 16'd0);
    if (!holdReq) bus.req = 2'b00;
    applyStimulus(2'($urandom), 16'($urandom), 16'($urandom));
    tick();
    checkOutput("gnt_pulse", {14'd0, bus.gnt}, 16'd0);
    checkOutput("rx_addr", {15'd0, bus.ram_rx_valid}, 16'd1);
    checkOutput("din_addr", {6'd0, bus.ram_din}, {6'd0, (expWe ? 2'b00 : 2'b10), expAddr});
    tick();
    checkOutput("rx_data", {15'd0, bus.ram_rx_valid}, 16'd1);
    checkOutput("din_data", {6'd0, bus.ram_din},
                expWe ? {6'd0, 2'b01, expWdata} : {6'd0, 2'b11, 8'h00});
    if (expWe) begin
      tick();
      checkOutput("wr_rsp_valid", {14'd0, bus.rsp_valid}, {14'd0, oneHot});
      checkOutput("wr_rsp_rdata", {8'd0, bus.rsp_rdata}, 16'd0);
      checkOutput("wr_rsp_err", {15'd0, bus.rsp_err}, 16'd0);
      checkOutput("wr_rx_idle", {15'd0, bus.ram_rx_valid}, 16'd0);
      return;
    end
    if (txDelay < 0) begin
`ifdef SPI_RAM_ARB_TIMEOUT_EN
      for (int i = 0; i < TxTimeout; i++) begin
        tick();
        checkOutput("to_no_early_rsp", {14'd0, bus.rsp_valid}, 16'd0);
      end
      tick();
      checkOutput("to_rsp_valid", {14'd0, bus.rsp_valid}, {14'd0, oneHot});
      checkOutput("to_rsp_err", {15'd0, bus.rsp_err}, 16'd1);
      checkOutput("to_rsp_rdata", {8'd0, bus.rsp_rdata}, 16'd0);
`else
      for (int i = 0; i < 40; i++) begin
        tick();
        checkOutput("stall_no_rsp", {14'd0, bus.rsp_valid}, 16'd0);
        checkOutput("stall_busy", {15'd0, bus.busy}, 16'd1);
      end
`endif
      return;
    end
    for (int i = 0; i < txDelay; i++) begin
      bus.ram_dout = 8'($urandom);
      tick();
      checkOutput("rd_wait_no_rsp", {14'd0, bus.rsp_valid}, 16'd0);
      checkOutput("rd_wait_rx", {15'd0, bus.ram_rx_valid}, 16'd0);
    end
    bus.ram_tx_valid = 1'b1;
    bus.ram_dout     = ramData;
    tick();
    bus.ram_tx_valid = 1'b0;
    bus.ram_dout     = 8'($urandom);
    checkOutput("rd_no_rsp_yet", {14'd0, bus.rsp_valid}, 16'd0);
    tick();
    checkOutput("rd_rsp_valid", {14'd0, bus.rsp_valid}, {14'd0, oneHot});
    checkOutput("rd_rsp_rdata", {8'd0, bus.rsp_rdata}, {8'd0, ramData});
    checkOutput("rd_rsp_err", {15'd0, bus.rsp_err}, 16'd0);
    checkOutput("rd_busy_done", {15'd0, bus.busy}, 16'd0);
  endtask

  initial begin
    $display("[TB] start");
    bus.req = 2'b00;
    bus.ram_tx_valid = 1'b0;
    bus.ram_dout = 8'h00;
    applyStimulus(2'b00, 16'h0000, 16'h0000);
    doReset(2);
    checkOutput("rst_gnt", {14'd0, bus.gnt}, 16'd0);
    checkOutput("rst_rsp_valid", {14'd0, bus.rsp_valid}, 16'd0);
    checkOutput("rst_rsp_rdata", {8'd0, bus.rsp_rdata}, 16'd0);
    checkOutput("rst_rsp_err", {15'd0, bus.rsp_err}, 16'd0);
    checkOutput("rst_din", {6'd0, bus.ram_din}, 16'd0);
    checkOutput("rst_rx", {15'd0, bus.ram_rx_valid}, 16'd0);
    checkOutput("rst_busy", {15'd0, bus.busy}, 16'd0);

    // Directed write from requester 0, then read of the same address from requester 1.
    applyStimulus(2'b01, 16'h003C, 16'h00A5);
    doTxn(2'b01, 1'b0, 0, 8'h00);
    tick();
    applyStimulus(2'b00, 16'h3C00, 16'h0000);
    doTxn(2'b10, 1'b0, 1, 8'hA5);
    tick();

    // Both requesters held from reset: grants must alternate 0,1,0,1.
    doReset(1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'($urandom), 16'($urandom), 16'($urandom));
      doTxn(2'b11, 1'b1, $urandom_range(0, 2), 8'($urandom));
    end
    bus.req = 2'b00;
    tick();

    // Reset while the write sits in DATA: nothing may come out afterwards.
    doReset(1);
    applyStimulus(2'b11, 16'h5566, 16'h7788);
    bus.req = 2'b01;
    tick();
    bus.req = 2'b00;
    tick();
    rst = 1'b1;
    tick();
    checkOutput("midrst_gnt", {14'd0, bus.gnt}, 16'd0);
    checkOutput("midrst_rx", {15'd0, bus.ram_rx_valid}, 16'd0);
    checkOutput("midrst_din", {6'd0, bus.ram_din}, 16'd0);
    checkOutput("midrst_busy", {15'd0, bus.busy}, 16'd0);
    checkOutput("midrst_rsp", {14'd0, bus.rsp_valid}, 16'd0);
    rst = 1'b0;
    rrLast = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("midrst_no_rsp", {14'd0, bus.rsp_valid}, 16'd0);
      checkOutput("midrst_no_rx", {15'd0, bus.ram_rx_valid}, 16'd0);
    end

    // Spurious tx_valid in IDLE is ignored; the following write has normal timing.
    bus.ram_tx_valid = 1'b1;
    bus.ram_dout = 8'h5A;
    tick();
    tick();
    bus.ram_tx_valid = 1'b0;
    checkOutput("spur_no_rsp", {14'd0, bus.rsp_valid}, 16'd0);
    checkOutput("spur_idle", {15'd0, bus.busy}, 16'd0);
    applyStimulus(2'b01, 16'h00FF, 16'h00FF);
    doTxn(2'b01, 1'b0, 0, 8'h00);
    tick();

    // Read that the RAM never answers.
    applyStimulus(2'b00, 16'h0042, 16'h0000);
    doTxn(2'b01, 1'b0, -1, 8'h00);
    doReset(1);
    // tx_valid landing on the last allowed WAIT_TX cycle.
    applyStimulus(2'b00, 16'hFF00, 16'h0000);
    doTxn(2'b10, 1'b0, TxTimeout - 1, 8'hFF);
    tick();

    // Randomized traffic.
    for (int i = 0; i < 30; i++) begin
      applyStimulus(2'($urandom), 16'($urandom), 16'($urandom));
      doTxn(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 5), 8'($urandom));
    end
    bus.req = 2'b00;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
